input_tile_scheduler: RTL and testbench

//  Sequences input_router across a full conv layer: one tile = one output row y.
//  Per tile: clears router, programs the tile-read window, enables routing, waits for route done,

---
 rtl/router_pkg.sv | 20 ++
 rtl/tile_addr_calc.sv | 55 +++++
 rtl/input_tile_scheduler.sv | 176 +++++++++++++++++
 tb/tb_input_tile_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and default sizing for the input tile scheduler and its address calculator.
package router_pkg;

    localparam int ADDR_WIDTH_DEF   = 8;
    localparam int KERNEL_SIZE_DEF  = 3;
    localparam int ROUTER_COUNT_DEF = 4;
    localparam int TIMEOUT_W_DEF    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_ROUTE,
        S_DRAIN,
        S_NEXT,
        S_ABORT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/tile_addr_calc.sv
// Registered tile read window: start = base + idx*stride*size, end = start + K*size - 1,
// with a flag when either value does not fit in ADDR_WIDTH bits.
module tile_addr_calc
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] size_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    output logic [ADDR_WIDTH-1:0] start_o,
    output logic [ADDR_WIDTH-1:0] end_o,
    output logic                  ovf_o
);

    // Wide enough that idx*stride*size + base + K*size can never wrap.
    localparam int WW = 3 * ADDR_WIDTH + 2;

    logic [WW-1:0]         prod_w, span_w, start_w, end_w;
    logic [ADDR_WIDTH-1:0] start_q, start_d, end_q, end_d;
    logic                  ovf_q, ovf_d;

    // Full-precision window arithmetic; a zero-height window collapses to end == start.
    always_comb begin
        prod_w  = WW'(idx_i) * WW'(stride_i) * WW'(size_i);
        span_w  = WW'(KERNEL_SIZE) * WW'(size_i);
        start_w = WW'(base_i) + prod_w;
        end_w   = (span_w == '0) ? start_w : start_w + span_w - WW'(1);
        start_d = start_w[ADDR_WIDTH-1:0];
        end_d   = end_w[ADDR_WIDTH-1:0];
        ovf_d   = (end_w[WW-1:ADDR_WIDTH] != '0);
    end

    // Window registers; the scheduler feeds next-state config so results line up with CLEAR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q <= '0;
            end_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_o = start_q;
    assign end_o   = end_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/input_tile_scheduler.sv
// Walks input_router across a conv layer one output row at a time:
// clear, program window, route, then meter ROUTER_COUNT beats to the PE array.
module input_tile_scheduler
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
    parameter int ROUTER_COUNT = ROUTER_COUNT_DEF,
    parameter int TIMEOUT_W    = TIMEOUT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic                  i_route_done,
    input  logic                  i_data_out_ready,
    input  logic                  i_array_ready,
    output logic                  o_router_en,
    output logic                  o_router_clear,
    output logic [ADDR_WIDTH-1:0] o_start_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_end,
    output logic                  o_data_out_en,
    output logic [ADDR_WIDTH-1:0] o_tile_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int TW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam int BW = $clog2(ROUTER_COUNT + 1);

    sched_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, isize_q, isize_d;
    logic [ADDR_WIDTH-1:0] osize_q, osize_d, stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  err_q, err_d, done_q;
    logic [BW-1:0]         beat_q, beat_d;
    logic [TW-1:0]         wd_q, wd_d;
    logic                  router_en, router_clear, dout_en, calc_ovf;

    // Window is computed from next-state config/index so it is registered and valid in CLEAR.
    tile_addr_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE)
    ) u_calc (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .base_i  (base_d),
        .size_i  (isize_d),
        .stride_i(stride_d),
        .idx_i   (idx_d),
        .start_o (o_start_addr),
        .end_o   (o_addr_end),
        .ovf_o   (calc_ovf)
    );

    // Next-state and router handshake decode.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        isize_d      = isize_q;
        osize_d      = osize_q;
        stride_d     = stride_q;
        idx_d        = idx_q;
        err_d        = err_q;
        beat_d       = beat_q;
        wd_d         = wd_q;
        router_en    = 1'b0;
        router_clear = 1'b0;
        dout_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q still counts as busy, so a start on the done cycle is dropped.
                if (i_start && !i_abort && !done_q) begin
                    base_d   = i_base_addr;
                    isize_d  = i_i_size;
                    osize_d  = i_o_size;
                    stride_d = (i_stride == '0) ? ADDR_WIDTH'(1) : i_stride;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    state_d  = (i_o_size == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                router_clear = 1'b1;
                if (calc_ovf) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                router_en = 1'b1;
                wd_d      = '0;
                beat_d    = '0;
                state_d   = S_ROUTE;
            end
            S_ROUTE: begin
                router_en = 1'b1;
                if (i_route_done) begin
                    state_d = S_DRAIN;
                end else if (TIMEOUT_W > 0) begin
                    wd_d = wd_q + TW'(1);
                    if (wd_d == '1) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                dout_en = i_data_out_ready & i_array_ready;
                if (dout_en) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(ROUTER_COUNT - 1)) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                idx_d   = idx_q + ADDR_WIDTH'(1);
                state_d = (idx_q == osize_q - ADDR_WIDTH'(1)) ? S_DONE : S_CLEAR;
            end
            S_ABORT: begin
                router_clear = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort is not taken once the layer is already finishing (ABORT/DONE).
        // A CLEAR cycle already clears the router, so it goes straight to DONE.
        if (i_abort && (state_q inside {S_CLEAR, S_LAUNCH, S_ROUTE, S_DRAIN, S_NEXT})) begin
            err_d   = 1'b1;
            state_d = (state_q == S_CLEAR) ? S_DONE : S_ABORT;
        end
    end

    // State, latched config, counters and the registered done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            isize_q  <= '0;
            osize_q  <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            isize_q  <= isize_d;
            osize_q  <= osize_d;
            stride_q <= stride_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            wd_q     <= wd_d;
            done_q   <= (state_q == S_DONE);
        end
    end

    assign o_router_en    = router_en;
    assign o_router_clear = router_clear;
    assign o_data_out_en  = dout_en;
    assign o_tile_idx     = idx_q;
    assign o_busy         = (state_q != S_IDLE) | done_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_input_tile_scheduler.sv
// Scoreboarded bench for input_tile_scheduler: expected windows are pushed at start and
// popped on each router launch; per-scenario tasks check counts, flags and timing.
module tb_input_tile_scheduler;

    logic       clk, rst;
    logic       i_start, i_abort, i_route_done, i_data_out_ready, i_array_ready;
    logic [7:0] i_base_addr, i_i_size, i_o_size, i_stride;
    logic       o_router_en, o_router_clear, o_data_out_en, o_busy, o_done, o_err;
    logic [7:0] o_start_addr, o_addr_end, o_tile_idx;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] s;
        logic [7:0] e;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   n_pass = 0, n_total = 0;
    int   n_clear = 0, n_en_cyc = 0, n_en_rise = 0, n_done = 0, n_beats = 0;
    logic en_prev = 1'b0;
    logic [7:0] cur_s = '0, cur_e = '0;

    input_tile_scheduler #(.TIMEOUT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_base_addr(i_base_addr), .i_i_size(i_i_size), .i_o_size(i_o_size),
        .i_stride(i_stride), .i_route_done(i_route_done),
        .i_data_out_ready(i_data_out_ready), .i_array_ready(i_array_ready),
        .o_router_en(o_router_en), .o_router_clear(o_router_clear),
        .o_start_addr(o_start_addr), .o_addr_end(o_addr_end),
        .o_data_out_en(o_data_out_en), .o_tile_idx(o_tile_idx),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples mid low phase; pops the scoreboard on each launch.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            en_prev = 1'b0;
        end else begin
            if (o_router_clear) n_clear++;
            if (o_router_en) n_en_cyc++;
            if (o_done) n_done++;
            if (o_router_en && !en_prev) begin
                n_en_rise++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_underflow: launch idx=%0d start=%0d end=%0d with no expected tile",
                             o_tile_idx, o_start_addr, o_addr_end);
                end else begin
                    ex = sb.pop_front();
                    if ({o_tile_idx, o_start_addr, o_addr_end} !== {ex.idx, ex.s, ex.e})
                        $display("FAIL tile_window: got idx=%0d start=%0d end=%0d exp idx=%0d start=%0d end=%0d",
                                 o_tile_idx, o_start_addr, o_addr_end, ex.idx, ex.s, ex.e);
                    else n_pass++;
                end
                cur_s = o_start_addr;
                cur_e = o_addr_end;
            end
            if (o_data_out_en) begin
                n_beats++;
                n_total++;
                if ({o_start_addr, o_addr_end, i_data_out_ready, i_array_ready} !== {cur_s, cur_e, 2'b11})
                    $display("FAIL beat_window: got start=%0d end=%0d rdy=%b%b exp start=%0d end=%0d rdy=11",
                             o_start_addr, o_addr_end, i_data_out_ready, i_array_ready, cur_s, cur_e);
                else n_pass++;
            end
            en_prev = o_router_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1, "bench timeout");
    end

    task automatic clr_counts();
        n_clear = 0; n_en_cyc = 0; n_en_rise = 0; n_done = 0; n_beats = 0;
    endtask

    // Drives one start pulse and pushes the model's expected launched windows.
    task automatic pulse_start(input int b, input int isz, input int osz, input int st);
        int  guard;
        int  ste;
        longint s, e;
        guard = 0;
        @(negedge clk);
        while (o_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        i_start = 1'b1;
        i_base_addr = 8'(b); i_i_size = 8'(isz); i_o_size = 8'(osz); i_stride = 8'(st);
        ste = (st == 0) ? 1 : st;
        for (int y = 0; y < osz; y++) begin
            s = longint'(b) + longint'(y) * ste * isz;
            e = (isz == 0) ? s : s + 3 * isz - 1;
            if (s > 255 || e > 255) break;
            sb.push_back('{idx: 8'(y), s: 8'(s), e: 8'(e)});
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Acts as the router until o_done: route_done after route_lat enable cycles (0 = never).
    task automatic run_until_done(input int budget, input int route_lat, input bit toggle_ar,
                                  output bit got);
        int en_cnt, cyc;
        en_cnt = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (o_done) got = 1'b1;
            if (o_router_en) en_cnt++; else en_cnt = 0;
            i_route_done  = (route_lat > 0) && (en_cnt == route_lat);
            i_array_ready = toggle_ar ? cyc[0] : 1'b1;
        end
        i_route_done = 1'b0;
        i_array_ready = 1'b1;
        #4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_router_en, o_router_clear, o_start_addr, o_addr_end, o_data_out_en,
             o_tile_idx, o_busy, o_done, o_err} !== 30'd0)
            $display("FAIL reset_outputs: got %0h exp 0", {o_router_en, o_router_clear, o_start_addr,
                     o_addr_end, o_data_out_en, o_tile_idx, o_busy, o_done, o_err});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit got;
        clr_counts();
        pulse_start(0, 6, 4, 1);
        n_total++;
        if ({o_router_clear, o_router_en, o_busy} !== 3'b101)
            $display("FAIL basic_clear_cycle: got %b exp 101", {o_router_clear, o_router_en, o_busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_router_clear, o_router_en} !== 2'b01)
            $display("FAIL basic_launch_latency: got %b exp 01", {o_router_clear, o_router_en});
        else n_pass++;
        run_until_done(300, 3, 1'b0, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL basic_done_seen: got %0d exp 1", got); else n_pass++;
        n_total++;
        if ({n_en_rise, n_clear, n_done, n_beats} !== {32'd4, 32'd4, 32'd1, 32'd16})
            $display("FAIL basic_counts: got en=%0d clr=%0d done=%0d beats=%0d exp 4 4 1 16",
                     n_en_rise, n_clear, n_done, n_beats);
        else n_pass++;
        n_total++;
        if (o_err !== 1'b0) $display("FAIL basic_err: got %0d exp 0", o_err); else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL basic_sb_left: got %0d exp 0", sb.size()); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_busy, o_done} !== 2'b00)
            $display("FAIL basic_busy_drop: got %b exp 00", {o_busy, o_done});
        else n_pass++;
    endtask

    task automatic test_stride_ignored_start();
        bit got;
        clr_counts();
        pulse_start(10, 9, 4, 2);
        i_start = 1'b1; i_base_addr = 8'd99; i_o_size = 8'd1; i_stride = 8'd5;
        @(negedge clk);
        i_start = 1'b0;
        run_until_done(300, 2, 1'b1, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL stride_done_seen: got %0d exp 1", got); else n_pass++;
        n_total++;
        if ({n_en_rise, n_clear, n_done} !== {32'd4, 32'd4, 32'd1})
            $display("FAIL stride_counts: got en=%0d clr=%0d done=%0d exp 4 4 1",
                     n_en_rise, n_clear, n_done);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL stride_sb_left: got %0d exp 0", sb.size()); else n_pass++;
    endtask

    task automatic test_zero_tiles();
        clr_counts();
        pulse_start(0, 6, 0, 1);
        n_total++;
        if ({o_done, o_busy} !== 2'b01) $display("FAIL zero_cycle1: got %b exp 01", {o_done, o_busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_done, o_busy, o_err} !== 3'b110)
            $display("FAIL zero_done_pulse: got %b exp 110", {o_done, o_busy, o_err});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_done, o_busy, n_en_cyc} !== {2'b00, 32'd0})
            $display("FAIL zero_after: got done=%b busy=%b en=%0d exp 0 0 0", o_done, o_busy, n_en_cyc);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit got;
        clr_counts();
        pulse_start(200, 20, 4, 1);
        run_until_done(50, 2, 1'b0, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL ovf_done_seen: got %0d exp 1", got); else n_pass++;
        n_total++;
        if ({o_err, n_en_cyc, n_clear} !== {1'b1, 32'd0, 32'd1})
            $display("FAIL ovf_result: got err=%0d en=%0d clr=%0d exp 1 0 1", o_err, n_en_cyc, n_clear);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit got;
        clr_counts();
        pulse_start(0, 4, 2, 1);
        run_until_done(100, 0, 1'b0, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL timeout_done_seen: got %0d exp 1", got); else n_pass++;
        n_total++;
        if ({o_err, n_en_cyc, n_done} !== {1'b1, 32'd16, 32'd1})
            $display("FAIL timeout_result: got err=%0d en_cycles=%0d done=%0d exp 1 16 1",
                     o_err, n_en_cyc, n_done);
        else n_pass++;
        n_total++;
        if (sb.size() != 1) $display("FAIL timeout_sb_left: got %0d exp 1", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_abort();
        bit got, hit, prev;
        int en_cnt, nc;
        clr_counts();
        hit = 1'b0; prev = 1'b0; en_cnt = 0;
        pulse_start(0, 6, 4, 1);
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (prev && !o_router_en) begin
                hit = 1'b1;
                i_abort = 1'b1;
                i_route_done = 1'b0;
            end else begin
                if (o_router_en) en_cnt++; else en_cnt = 0;
                i_route_done = (en_cnt == 2);
            end
            prev = o_router_en;
            i_array_ready = c[0];
        end
        nc = n_clear;
        n_total++;
        if (hit !== 1'b1) $display("FAIL abort_reach_drain: got %0d exp 1", hit); else n_pass++;
        @(negedge clk);
        i_abort = 1'b0;
        n_total++;
        if ({o_router_clear, o_router_en, o_err} !== 3'b101)
            $display("FAIL abort_clear_cycle: got %b exp 101", {o_router_clear, o_router_en, o_err});
        else n_pass++;
        run_until_done(20, 0, 1'b1, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL abort_done_seen: got %0d exp 1", got); else n_pass++;
        n_total++;
        if ({n_clear, n_done, 31'd0, o_err} !== {nc + 1, 32'd1, 32'd1})
            $display("FAIL abort_result: got clr=%0d done=%0d err=%0d exp %0d 1 1",
                     n_clear, n_done, o_err, nc + 1);
        else n_pass++;
        n_total++;
        if (sb.size() != 3) $display("FAIL abort_sb_left: got %0d exp 3", sb.size()); else n_pass++;
        sb.delete();
        pulse_start(0, 6, 0, 1);
        n_total++;
        if (o_err !== 1'b0) $display("FAIL abort_err_cleared: got %0d exp 0", o_err); else n_pass++;
        run_until_done(10, 0, 1'b0, got);
    endtask

    task automatic test_idle_abort_wins();
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_route_done = 1'b1;
        i_base_addr = 8'd0; i_i_size = 8'd6; i_o_size = 8'd2; i_stride = 8'd1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        @(negedge clk);
        i_route_done = 1'b0;
        n_total++;
        if ({o_busy, o_err, o_router_clear, o_router_en} !== 4'b0000)
            $display("FAIL idle_abort_wins: got %b exp 0000", {o_busy, o_err, o_router_clear, o_router_en});
        else n_pass++;
    endtask

    task automatic test_reset_mid_layer();
        clr_counts();
        pulse_start(0, 6, 4, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_router_en, o_router_clear, o_start_addr, o_addr_end, o_tile_idx, o_busy, o_done, o_err} !== 29'd0)
            $display("FAIL reset_mid_outputs: got %0h exp 0", {o_router_en, o_router_clear, o_start_addr,
                     o_addr_end, o_tile_idx, o_busy, o_done, o_err});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        #4;
        n_total++;
        if ({o_busy, n_done} !== {1'b0, 32'd0})
            $display("FAIL reset_mid_quiet: got busy=%0d done=%0d exp 0 0", o_busy, n_done);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_route_done = 1'b0;
        i_data_out_ready = 1'b1; i_array_ready = 1'b1;
        i_base_addr = '0; i_i_size = '0; i_o_size = '0; i_stride = '0;
        test_reset();
        test_basic();
        test_stride_ignored_start();
        test_zero_tiles();
        test_overflow();
        test_timeout();
        test_abort();
        test_idle_abort_wins();
        test_reset_mid_layer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
